// File: rtl/biquad_multichannel.sv
// Time-multiplexed Direct-Form-I biquad serving CHANNELS channels through one multiplier.
// Each accepted sample takes five MAC cycles plus one output cycle. Coefficients are
// double-buffered so that a commit never lands mid-computation.
module biquad_multichannel #(
    parameter int unsigned W        = 16,
    parameter int unsigned CW       = 32,
    parameter int unsigned FRAC     = 30,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CHW-1:0]       in_chan,
    input  logic signed [W-1:0]  in_data,
    output logic                 out_valid,
    output logic [CHW-1:0]       out_chan,
    output logic signed [W-1:0]  out_data,
    input  logic                 bypass,
    input  logic                 clear,
    input  logic                 coef_we,
    input  logic [2:0]           coef_addr,
    input  logic signed [CW-1:0] coef_data,
    input  logic                 coef_commit
);

    localparam int unsigned NCOEF = 5;
    localparam int unsigned PW    = W + CW;
    localparam int unsigned AW    = W + CW + 3;

    localparam logic signed [CW-1:0] Unity = CW'(1) << FRAC;
    localparam logic signed [AW-1:0] Half  = AW'(1) << (FRAC - 1);

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [CHW-1:0]        chan_q, chan_d;
    logic signed [W-1:0]   x_q, x_d;
    logic                  byp_q, byp_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic                  out_valid_q, out_valid_d;
    logic signed [W-1:0]   out_data_q, out_data_d;
    logic [CHW-1:0]        out_chan_q, out_chan_d;
    logic                  rotate;

    logic signed [CW-1:0]  shadow_q [NCOEF];
    logic signed [CW-1:0]  shadow_d [NCOEF];
    logic signed [CW-1:0]  active_q [NCOEF];
    logic                  pending_q, pending_d;
    logic                  copy;

    logic signed [W-1:0]   x1_q [CHANNELS];
    logic signed [W-1:0]   x2_q [CHANNELS];
    logic signed [W-1:0]   y1_q [CHANNELS];
    logic signed [W-1:0]   y2_q [CHANNELS];

    logic                  accept;
    logic                  chan_ok;
    logic signed [CW-1:0]  mul_coef;
    logic signed [W-1:0]   mul_samp;
    logic signed [PW-1:0]  samp_ext, coef_ext, prod;
    logic signed [AW-1:0]  prod_ext;
    logic signed [AW-1:0]  rnd, scaled;
    logic signed [W-1:0]   sat_y, result;

    assign in_ready = reset_n && (state_q == StIdle) && !clear;
    assign accept   = in_valid && in_ready;
    assign chan_ok  = 32'(in_chan) < CHANNELS;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

    // Select coefficient/history pair for the current MAC term.
    always_comb begin
        mul_coef = active_q[0];
        mul_samp = x_q;
        unique case (cnt_q)
            3'd0: begin mul_coef = active_q[0]; mul_samp = x_q;          end
            3'd1: begin mul_coef = active_q[1]; mul_samp = x1_q[chan_q]; end
            3'd2: begin mul_coef = active_q[2]; mul_samp = x2_q[chan_q]; end
            3'd3: begin mul_coef = active_q[3]; mul_samp = y1_q[chan_q]; end
            3'd4: begin mul_coef = active_q[4]; mul_samp = y2_q[chan_q]; end
            default: ;
        endcase
    end

    // Exact product via explicit sign extension; the full-precision sum is never truncated.
    assign samp_ext = {{CW{mul_samp[W-1]}}, mul_samp};
    assign coef_ext = {{W{mul_coef[CW-1]}}, mul_coef};
    assign prod     = samp_ext * coef_ext;
    assign prod_ext = {{(AW - PW){prod[PW-1]}}, prod};

    // Round half up, rescale and saturate the finished accumulation.
    assign rnd    = acc_q + Half;
    assign scaled = rnd >>> FRAC;
    always_comb begin
        sat_y = scaled[W-1:0];
        if (scaled[AW-1:W-1] != {(AW - W + 1){scaled[AW-1]}}) begin
            sat_y = scaled[AW-1] ? {1'b1, {(W - 1){1'b0}}} : {1'b0, {(W - 1){1'b1}}};
        end
    end
    assign result = byp_q ? x_q : sat_y;

    // FSM next state, accumulator and output strobe.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        chan_d      = chan_q;
        x_d         = x_q;
        byp_d       = byp_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        rotate      = 1'b0;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept && chan_ok) begin
                        state_d = StMac;
                        cnt_d   = 3'd0;
                        acc_d   = '0;
                        chan_d  = in_chan;
                        x_d     = in_data;
                        byp_d   = bypass;
                    end
                end
                StMac: begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd4) state_d = StOut;
                end
                StOut: begin
                    out_valid_d = 1'b1;
                    out_data_d  = result;
                    out_chan_d  = chan_q;
                    rotate      = 1'b1;
                    state_d     = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            chan_q      <= '0;
            x_q         <= '0;
            byp_q       <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            chan_q      <= chan_d;
            x_q         <= x_d;
            byp_q       <= byp_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    // Shadow write and deferred commit; the copy takes this cycle's write into account.
    always_comb begin
        for (int i = 0; i < NCOEF; i++) begin
            shadow_d[i] = shadow_q[i];
            if (coef_we && (coef_addr == 3'(i))) shadow_d[i] = coef_data;
        end
        copy      = (pending_q || coef_commit) && (state_q == StIdle) && !accept;
        pending_d = (pending_q || coef_commit) && !copy;
    end

    // Coefficient registers; reset to a unity passthrough.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCOEF; i++) begin
                shadow_q[i] <= (i == 0) ? Unity : '0;
                active_q[i] <= (i == 0) ? Unity : '0;
            end
            pending_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCOEF; i++) begin
                shadow_q[i] <= shadow_d[i];
                if (copy) active_q[i] <= shadow_d[i];
            end
            pending_q <= pending_d;
        end
    end

    // Per-channel history; only the finishing channel rotates, clear wipes all.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                x1_q[c] <= '0;
                x2_q[c] <= '0;
                y1_q[c] <= '0;
                y2_q[c] <= '0;
            end
        end else if (clear) begin
            for (int c = 0; c < CHANNELS; c++) begin
                x1_q[c] <= '0;
                x2_q[c] <= '0;
                y1_q[c] <= '0;
                y2_q[c] <= '0;
            end
        end else if (rotate) begin
            x2_q[chan_q] <= x1_q[chan_q];
            x1_q[chan_q] <= x_q;
            y2_q[chan_q] <= y1_q[chan_q];
            y1_q[chan_q] <= result;
        end
    end

endmodule

// File: tb/tb_biquad_multichannel.sv
// Self-checking bench for biquad_multichannel: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural filter model.
module tb_biquad_multichannel;

    localparam int W    = 16;
    localparam int CW   = 32;
    localparam int FRAC = 30;
    localparam int CH   = 2;
    localparam int CHW  = 1;

    localparam int OpS   = 0;
    localparam int OpClr = 1;
    localparam int OpW   = 2;
    localparam int OpC   = 3;

    localparam longint ONE   = longint'(1) <<< FRAC;
    localparam longint IB0   = 981467136;
    localparam longint IB1   = -1962934272;
    localparam longint IA1   = 1946157056;
    localparam longint IA2   = -889192448;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [CHW-1:0]       in_chan = '0;
    logic signed [W-1:0]  in_data = '0;
    logic                 out_valid;
    logic [CHW-1:0]       out_chan;
    logic signed [W-1:0]  out_data;
    logic                 bypass = 1'b0;
    logic                 clear = 1'b0;
    logic                 coef_we = 1'b0;
    logic [2:0]           coef_addr = '0;
    logic signed [CW-1:0] coef_data = '0;
    logic                 coef_commit = 1'b0;

    always #5 clk = ~clk;

    biquad_multichannel #(
        .W(W), .CW(CW), .FRAC(FRAC), .CHANNELS(CH), .CHW(CHW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_chan(in_chan), .in_data(in_data), .out_valid(out_valid), .out_chan(out_chan),
        .out_data(out_data), .bypass(bypass), .clear(clear), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state: coefficient sets and per-channel sample history.
    longint m_act [5];
    longint m_sh  [5];
    int     mx1 [CH];
    int     mx2 [CH];
    int     my1 [CH];
    int     my2 [CH];

    typedef struct {
        int     op;
        int     ch;
        longint val;
        bit     byp;
        int     want;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input longint got, input longint want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    function automatic void model_hist_zero();
        for (int c = 0; c < CH; c++) begin
            mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) begin
            m_act[i] = (i == 0) ? ONE : 0;
            m_sh[i]  = m_act[i];
        end
        model_hist_zero();
    endfunction

    // y = sum of coefficient*sample, rounded half up to integer, clamped to W bits.
    function automatic int model_eval(input int ch, input int x, input bit byp);
        longint acc;
        if (byp) return x;
        acc = m_act[0] * x + m_act[1] * mx1[ch] + m_act[2] * mx2[ch]
            + m_act[3] * my1[ch] + m_act[4] * my2[ch];
        acc = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    function automatic void model_push(input int ch, input int x, input int y);
        mx2[ch] = mx1[ch]; mx1[ch] = x;
        my2[ch] = my1[ch]; my1[ch] = y;
    endfunction

    // Offer one sample, follow it to its result and check latency, data, channel, strobe width.
    task automatic send(input int ch, input int x, input bit byp, input bit use_want,
                        input int want, input string name, input bit mid_commit);
        int k;
        int y;
        k = 0;
        while (!in_ready && k < 20) begin @(negedge clk); k++; end
        check({name, " in_ready"}, longint'(in_ready), 1);
        y = model_eval(ch, x, byp);
        if (use_want) y = want;
        in_valid = 1'b1; in_chan = CHW'(ch); in_data = W'(x); bypass = byp;
        @(negedge clk);
        in_valid = 1'b0; bypass = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            if (mid_commit && k == 2) begin
                coef_we = 1'b1; coef_addr = 3'd0; coef_data = CW'(ONE >>> 1); coef_commit = 1'b1;
            end else begin
                coef_we = 1'b0; coef_commit = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        coef_we = 1'b0; coef_commit = 1'b0;
        check({name, " latency"}, k, 6);
        check({name, " out_data"}, longint'(out_data), y);
        check({name, " out_chan"}, longint'(out_chan), ch);
        @(negedge clk);
        check({name, " strobe width"}, longint'(out_valid), 0);
        model_push(ch, x, model_eval(ch, x, byp));
        if (mid_commit) begin
            m_sh[0] = ONE >>> 1;
            m_act = m_sh;
        end
    endtask

    // Coefficient write issued in IDLE with no handshake, so a commit lands this edge.
    task automatic coef(input int addr, input longint val, input bit commit);
        coef_we = 1'b1; coef_addr = 3'(addr); coef_data = CW'(val); coef_commit = commit;
        @(negedge clk);
        coef_we = 1'b0; coef_commit = 1'b0;
        m_sh[addr] = val;
        if (commit) m_act = m_sh;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        #1;
        check("in_ready during clear", longint'(in_ready), 0);
        @(negedge clk);
        clear = 1'b0;
        model_hist_zero();
    endtask

    task automatic load_impulse();
        coef(0, IB0, 0); coef(1, IB1, 0); coef(2, IB0, 0); coef(3, IA1, 0); coef(4, IA2, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        model_reset();

        // Directed vector table.
        tbl.push_back(vec_t'{OpS, 0, 1234, 0, 1234});
        tbl.push_back(vec_t'{OpS, 0, -32768, 0, -32768});
        tbl.push_back(vec_t'{OpS, 0, 32767, 0, 32767});
        tbl.push_back(vec_t'{OpClr, 0, 0, 0, 0});
        tbl.push_back(vec_t'{OpW, 0, IB0, 0, 0});
        tbl.push_back(vec_t'{OpW, 1, IB1, 0, 0});
        tbl.push_back(vec_t'{OpW, 2, IB0, 0, 0});
        tbl.push_back(vec_t'{OpW, 3, IA1, 0, 0});
        tbl.push_back(vec_t'{OpC, 4, IA2, 0, 0});
        tbl.push_back(vec_t'{OpS, 0, 1000, 0, 914});
        tbl.push_back(vec_t'{OpS, 0, 0, 0, -171});
        tbl.push_back(vec_t'{OpClr, 0, 0, 0, 0});
        tbl.push_back(vec_t'{OpS, 0, 1000, 0, 914});
        tbl.push_back(vec_t'{OpS, 1, 0, 0, 0});
        tbl.push_back(vec_t'{OpS, 0, 0, 0, -171});
        tbl.push_back(vec_t'{OpS, 1, 0, 0, 0});
        tbl.push_back(vec_t'{OpS, 0, 555, 1, 555});
        tbl.push_back(vec_t'{OpClr, 0, 0, 0, 0});
        tbl.push_back(vec_t'{OpW, 0, ONE, 0, 0});
        tbl.push_back(vec_t'{OpW, 1, ONE, 0, 0});
        tbl.push_back(vec_t'{OpW, 2, 0, 0, 0});
        tbl.push_back(vec_t'{OpW, 3, 0, 0, 0});
        tbl.push_back(vec_t'{OpC, 4, 0, 0, 0});
        tbl.push_back(vec_t'{OpS, 0, 30000, 0, 30000});
        tbl.push_back(vec_t'{OpS, 0, 30000, 0, 32767});
        tbl.push_back(vec_t'{OpClr, 0, 0, 0, 0});
        tbl.push_back(vec_t'{OpS, 0, -32768, 0, -32768});
        tbl.push_back(vec_t'{OpS, 0, -32768, 0, -32768});

        // Reset state.
        @(negedge clk);
        check("reset in_ready", longint'(in_ready), 0);
        check("reset out_valid", longint'(out_valid), 0);
        check("reset out_data", longint'(out_data), 0);
        check("reset out_chan", longint'(out_chan), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle in_ready", longint'(in_ready), 1);

        foreach (tbl[i]) begin
            case (tbl[i].op)
                OpS:     send(tbl[i].ch, int'(tbl[i].val), tbl[i].byp, 1'b1, tbl[i].want,
                              $sformatf("vec%0d", i), 1'b0);
                OpClr:   do_clear();
                OpW:     coef(tbl[i].ch, tbl[i].val, 1'b0);
                default: coef(tbl[i].ch, tbl[i].val, 1'b1);
            endcase
        end

        // Clear three cycles after acceptance aborts the sample.
        load_impulse();
        in_valid = 1'b1; in_chan = '0; in_data = 16'sd1000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_hist_zero();
        seen = 1'b0;
        repeat (15) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("clear abort out_valid", longint'(seen), 0);
        send(0, 1000, 1'b0, 1'b1, 914, "after clear", 1'b0);

        // Commit issued mid-MAC only affects the following sample.
        coef(0, ONE, 0); coef(1, 0, 0); coef(2, 0, 0); coef(3, 0, 0); coef(4, 0, 1);
        do_clear();
        send(0, 1000, 1'b0, 1'b1, 1000, "commit busy old", 1'b1);
        send(0, 1000, 1'b0, 1'b1, 500, "commit busy new", 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            if (i % 20 == 0) begin
                coef(0, longint'($signed($urandom) >>> 1), 0);
                coef(1, longint'($signed($urandom) >>> 1), 0);
                coef(2, longint'($signed($urandom) >>> 2), 0);
                coef(3, longint'($signed($urandom) >>> 3), 0);
                coef(4, longint'($signed($urandom) >>> 3), 1);
            end
            if ($urandom_range(15, 0) == 0) do_clear();
            send(int'($urandom_range(CH - 1, 0)), int'($signed(16'($urandom))),
                 ($urandom_range(7, 0) == 0), 1'b0, 0, $sformatf("rand%0d", i), 1'b0);
        end

        // Asynchronous reset mid-computation restores passthrough and zero history.
        in_valid = 1'b1; in_chan = 1'b1; in_data = 16'sd4321;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midop reset in_ready", longint'(in_ready), 0);
        check("midop reset out_valid", longint'(out_valid), 0);
        check("midop reset out_data", longint'(out_data), 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        send(1, 77, 1'b0, 1'b1, 77, "post reset", 1'b0);
        send(1, -5, 1'b0, 1'b1, -5, "post reset 2", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
